// File: rtl/mem_stage.sv
// Memory-access stage: waits for the data SRAM response, aligns/extends load data,
// and drives the writeback and hazard buses. Define MEM_LOAD_HALF_EN for halfword loads.
module mem_stage #(
  parameter int EXE_TO_MEM_W = 111,
  parameter int MEM_TO_WB_W  = 70,
  parameter int MEM_TO_ID_W  = 40
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    exe_to_mem_valid,
  output logic                    mem_allow_in,
  input  logic [EXE_TO_MEM_W-1:0] exe_to_mem_bus,
  input  logic                    wb_allow_in,
  output logic                    mem_to_wb_valid,
  output logic [MEM_TO_WB_W-1:0]  mem_to_wb_bus,
  output logic [MEM_TO_ID_W-1:0]  mem_to_id_bus,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata
);

  logic                    mem_valid;
  logic [EXE_TO_MEM_W-1:0] mem_reg;
  logic                    buf_valid;
  logic [31:0]             buf_rdata;

  // Fields pack from the LSB; the top bit of the 111-bit bus is spare.
  logic [31:0] pc;
  logic [31:0] rkd_value;
  logic [31:0] alu_result;
  logic        res_from_mem;
  logic        reg_we;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [4:0]  reg_waddr;
  logic [1:0]  sram_size;

  assign pc           = mem_reg[109:78];
  assign rkd_value    = mem_reg[77:46];
  assign alu_result   = mem_reg[45:14];
  assign res_from_mem = mem_reg[13];
  assign reg_we       = mem_reg[12];
  assign mem_en       = mem_reg[11];
  assign mem_we       = mem_reg[10:7];
  assign reg_waddr    = mem_reg[6:2];
  assign sram_size    = mem_reg[1:0];

  logic unused_fields;
  assign unused_fields = ^{mem_reg[110], rkd_value, mem_we};

  function automatic logic signed [31:0] sext_byte(input logic signed [7:0] b);
    logic signed [31:0] r;
    r = b;
    return r;
  endfunction

  function automatic logic signed [31:0] sext_half(input logic signed [15:0] h);
    logic signed [31:0] r;
    r = h;
    return r;
  endfunction

  logic mem_ready_go;
  logic rsp_accept;
  logic advance;
  logic load_pending;

  assign mem_ready_go    = ~mem_en | data_sram_data_ok | buf_valid;
  assign mem_allow_in    = ~mem_valid | (mem_ready_go & wb_allow_in);
  assign mem_to_wb_valid = mem_valid & mem_ready_go;
  assign advance         = mem_to_wb_valid & wb_allow_in;
  assign rsp_accept      = mem_valid & mem_en & ~buf_valid & data_sram_data_ok;
  assign load_pending    = mem_valid & res_from_mem & ~mem_ready_go;

  logic [31:0] rdata_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign rdata_sel = buf_valid ? buf_rdata : data_sram_rdata;

  always_comb begin
    byte_sel = rdata_sel[7:0];
    case (alu_result[1:0])
      2'b01:   byte_sel = rdata_sel[15:8];
      2'b10:   byte_sel = rdata_sel[23:16];
      2'b11:   byte_sel = rdata_sel[31:24];
      default: byte_sel = rdata_sel[7:0];
    endcase
  end

  always_comb begin
    load_data = rdata_sel;
    if (sram_size == 2'b00)
      load_data = sext_byte(byte_sel);
`ifdef MEM_LOAD_HALF_EN
    else if (sram_size == 2'b01)
      load_data = sext_half(alu_result[1] ? rdata_sel[31:16] : rdata_sel[15:0]);
`endif
  end

`ifndef MEM_LOAD_HALF_EN
  logic unused_half;
  assign unused_half = ^sext_half(16'h0);
`endif

  assign final_result  = res_from_mem ? load_data : alu_result;
  assign mem_to_wb_bus = {pc, reg_we & mem_valid, reg_waddr, final_result};
  assign mem_to_id_bus = {mem_valid, reg_we, reg_waddr, final_result, load_pending};

  // Control state and read-data buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid <= 1'b0;
      buf_valid <= 1'b0;
      buf_rdata <= 32'h0;
    end else begin
      if (mem_allow_in)
        mem_valid <= exe_to_mem_valid;
      if (advance)
        buf_valid <= 1'b0;
      else if (rsp_accept && !wb_allow_in) begin
        buf_valid <= 1'b1;
        buf_rdata <= data_sram_rdata;
      end
    end
  end

  // Instruction payload is data only and carries no reset
  always_ff @(posedge clk) begin
    if (mem_allow_in && exe_to_mem_valid)
      mem_reg <= exe_to_mem_bus;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LoongArch pipeline. Sits between the execute stage and the writeback stage.
- Accepts the execute-to-memory bus, waits for `data_sram_data_ok` on memory instructions, and aligns/extends load data.
- Produces the writeback bus and a hazard/forwarding bus to the decode stage.
- Holds one instruction. A one-entry read-data buffer covers writeback backpressure.

Parameters:
- EXE_TO_MEM_W, 111, width of the input bus, fields MSB→LSB: pc[31:0], rkd_value[31:0], alu_result[31:0], res_from_mem, reg_we, mem_en, mem_we[3:0], reg_waddr[4:0], sram_size[1:0]
- MEM_TO_WB_W, 70, width of the output bus, fields MSB→LSB: pc[31:0], reg_we, reg_waddr[4:0], final_result[31:0]
- MEM_TO_ID_W, 40, width of the hazard bus, fields MSB→LSB: mem_valid, reg_we, reg_waddr[4:0], final_result[31:0], load_pending

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- exe_to_mem_valid  in  1  upstream holds a valid instruction
- mem_allow_in  out  1  stage can accept this cycle
- exe_to_mem_bus  in  EXE_TO_MEM_W  instruction payload
- wb_allow_in  in  1  writeback can accept
- mem_to_wb_valid  out  1  stage presents a completed instruction
- mem_to_wb_bus  out  MEM_TO_WB_W  writeback payload
- mem_to_id_bus  out  MEM_TO_ID_W  hazard/forwarding info
- data_sram_data_ok  in  1  response for the oldest outstanding request
- data_sram_rdata  in  32  read data, valid with data_ok

Behaviour:
- State: mem_valid, mem_reg (captured bus), buf_valid, buf_rdata[31:0].
- Reset (reset=0, async): mem_valid=0, buf_valid=0, buf_rdata=0. mem_reg is not reset.
- Outputs in reset: mem_allow_in=1, mem_to_wb_valid=0, mem_to_id_bus[39]=0.
- Readiness:
  - mem_ready_go = !mem_en | data_sram_data_ok | buf_valid.
  - mem_allow_in = !mem_valid | (mem_ready_go & wb_allow_in).
  - mem_to_wb_valid = mem_valid & mem_ready_go.
- Capture: when mem_allow_in, mem_valid <= exe_to_mem_valid. When mem_allow_in & exe_to_mem_valid, mem_reg <= exe_to_mem_bus.
- Response acceptance:
  - data_ok is consumed only when mem_valid & mem_en & !buf_valid.
  - data_ok at any other time is ignored (must not occur in a correct system; the bench flags it).
  - Stores (mem_we≠0) also wait for data_ok. For stores, rdata is discarded.
- Buffering:
  - data_ok accepted while wb_allow_in=0: buf_rdata <= data_sram_rdata, buf_valid <= 1.
  - buf_valid clears in the cycle the instruction advances (mem_valid & mem_ready_go & wb_allow_in).
  - data_ok accepted with wb_allow_in=1: data passes straight through, buffer untouched. Latency from data_ok to mem_to_wb_valid is 0 cycles.
- Load data: rdata_sel = buf_valid ? buf_rdata : data_sram_rdata. Let sh = alu_result[1:0]*8.
  - size 00: byte = rdata_sel[sh+7:sh], sign-extended to 32 bits.
  - size 10: full word. No alignment check; the address is assumed word-aligned by the execute stage.
  - size 01/11: see Optional Feature.
- Result selection: final_result = res_from_mem ? load_data : alu_result.
- Writeback bus: mem_to_wb_bus = {pc, reg_we & mem_valid, reg_waddr, final_result}.
- Hazard bus: mem_to_id_bus = {mem_valid, reg_we, reg_waddr, final_result, load_pending}.
  - load_pending = mem_valid & res_from_mem & !mem_ready_go.
  - Decode must stall, not forward, while load_pending=1.
- Simultaneous events:
  - New capture and advance in the same cycle: buf_valid clears, the new entry starts with buf_valid=0.
  - data_ok and wb_allow_in in the same cycle as an upstream valid: all three complete in one cycle.
- Reset mid-operation: the in-flight instruction and buffer are dropped. A data_ok arriving after reset release with mem_valid=0 is ignored.

Optional Feature:
- Macro: MEM_LOAD_HALF_EN.
- Defined: size 01 selects halfword rdata_sel[alu_result[1]*16+15 : alu_result[1]*16], sign-extended. size 11 is treated as word.
- Undefined: sizes 01 and 11 are treated as word (size 10). No halfword mux is synthesized.

Test Plan:
- ALU op: bus with alu_result=0x0000_1234, mem_en=0, reg_we=1, waddr=5, wb_allow_in=1 → mem_to_wb_valid next cycle, final_result=0x0000_1234, mem_allow_in stays 1.
- ld.w: mem_en=1, res_from_mem=1, size=10, data_ok 3 cycles later with rdata=0xDEAD_BEEF → load_pending=1 for 3 cycles, then final_result=0xDEAD_BEEF in the data_ok cycle.
- ld.b: alu_result low bits=2'b11, rdata=0x80AA_BBCC → final_result=0xFFFF_FF80; with low bits 2'b00 → 0xFFFF_FFCC.
- Backpressure: data_ok with rdata=0x1122_3344 while wb_allow_in=0 for 2 cycles, rdata bus then changes to 0 → buf_valid=1; on release, final_result=0x1122_3344 and buf_valid clears.
- Store: mem_we=4'b1111, data_ok after 1 cycle → mem_to_wb_valid only in the data_ok cycle, with reg_we=0 on the writeback bus.
- Async reset asserted mid-wait, then a stray data_ok after release → mem_valid=0 immediately, no mem_to_wb_valid pulse. With MEM_LOAD_HALF_EN defined: size 01, alu_result[1]=1, rdata=0x8001_0000 → 0xFFFF_8001.
